id_operand_stage: RTL and testbench

Parametrised decode-to-execute operand stage that replaces the single-cycle combinational decode/forward path with a registered, handshaked stage. It takes already-decoded micro-ops, reads the register file, forwards from NBYP bypass channels, and tracks outstanding loads in a per-register scoreboard so load-use hazards stall precisely, including several loads in flight. It sits between the fetch/decode front end and the execute unit.

---
 rtl/id_operand_stage_pkg.sv | 26 ++
 rtl/id_operand_select.sv | 56 +++++
 rtl/id_operand_stage.sv | 181 ++++++++++++++++++
 tb/tb_id_operand_stage.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_operand_stage_pkg.sv
// Shared definitions for the decode-to-execute operand stage: widths,
// micro-op codes and a small address-match helper.
package id_operand_stage_pkg;

  localparam int XLEN_DEF = 32;
  localparam int OPW_DEF  = 6;
  localparam int RAW      = 5;
  localparam int NREG     = 32;

  localparam logic [OPW_DEF-1:0] INST_ADD  = 6'd0;
  localparam logic [OPW_DEF-1:0] INST_SUB  = 6'd1;
  localparam logic [OPW_DEF-1:0] INST_AND  = 6'd2;
  localparam logic [OPW_DEF-1:0] INST_OR   = 6'd3;
  localparam logic [OPW_DEF-1:0] INST_XOR  = 6'd4;
  localparam logic [OPW_DEF-1:0] INST_ADDI = 6'd5;
  localparam logic [OPW_DEF-1:0] INST_LW   = 6'd6;
  localparam logic [OPW_DEF-1:0] INST_SW   = 6'd7;
  localparam logic [OPW_DEF-1:0] INST_BEQ  = 6'd8;

  typedef logic [RAW-1:0] reg_addr_t;

  function automatic logic addr_hit(input logic valid, input reg_addr_t a, input reg_addr_t b);
    return valid && (a == b);
  endfunction

endpackage

// File: rtl/id_operand_select.sv
// Per-source operand priority mux (bypass, load writeback, register file)
// plus the load-use hazard bit for that source.
module id_operand_select
  import id_operand_stage_pkg::*;
#(
  parameter int NBYP = 2,
  parameter int XLEN = 32,
  parameter int CNTW = 3
) (
  input  logic [0:0]           i_en,
  input  logic [RAW-1:0]       i_addr,
  input  logic [XLEN-1:0]      i_rf_data,
  input  logic [NBYP-1:0]      i_byp_valid,
  input  logic [RAW*NBYP-1:0]  i_byp_addr,
  input  logic [XLEN*NBYP-1:0] i_byp_data,
  input  logic [0:0]           i_ld_valid,
  input  logic [RAW-1:0]       i_ld_rd,
  input  logic [XLEN-1:0]      i_ld_data,
  input  logic [CNTW-1:0]      i_cnt,
  output logic [XLEN-1:0]      o_data,
  output logic [0:0]           o_hazard
);

  logic            w_active;
  logic            w_ld_hit;
  logic            w_byp_hit;
  logic [XLEN-1:0] w_byp_data;

  assign w_active = i_en && (i_addr != {RAW{1'b0}});
  assign w_ld_hit = addr_hit(i_ld_valid, i_ld_rd, i_addr);

  // Scan from the oldest channel down so the lowest index wins.
  always_comb begin
    w_byp_hit  = 1'b0;
    w_byp_data = {XLEN{1'b0}};
    for (int k = NBYP - 1; k >= 0; k--) begin
      w_byp_data = addr_hit(i_byp_valid[k], i_byp_addr[k*RAW +: RAW], i_addr) ?
                   i_byp_data[k*XLEN +: XLEN] : w_byp_data;
      w_byp_hit  = w_byp_hit | addr_hit(i_byp_valid[k], i_byp_addr[k*RAW +: RAW], i_addr);
    end
    if (!w_active) begin
      o_data = {XLEN{1'b0}};
    end else if (w_byp_hit) begin
      o_data = w_byp_data;
    end else if (w_ld_hit) begin
      o_data = i_ld_data;
    end else begin
      o_data = i_rf_data;
    end
  end

  // A single outstanding load is resolved by its own same-cycle writeback.
  assign o_hazard = w_active &&
                    ((i_cnt > CNTW'(1)) || ((i_cnt == CNTW'(1)) && !w_ld_hit));

endmodule

// File: rtl/id_operand_stage.sv
// Registered decode-to-execute operand stage: operand forwarding, per-register
// outstanding-load scoreboard, load-use stalls and the output pipeline register.
module id_operand_stage
  import id_operand_stage_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NBYP     = 2,
  parameter int LD_DEPTH = 4,
  parameter int OPW      = OPW_DEF
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [XLEN-1:0]      in_pc,
  input  logic [XLEN-1:0]      in_imm,
  input  logic [OPW-1:0]       in_op,
  input  logic                 in_rs1_en,
  input  logic                 in_rs2_en,
  input  logic [RAW-1:0]       in_rs1_addr,
  input  logic [RAW-1:0]       in_rs2_addr,
  input  logic [RAW-1:0]       in_rd_addr,
  input  logic                 in_is_load,
  output logic [RAW-1:0]       rf_rd1_addr,
  output logic [RAW-1:0]       rf_rd2_addr,
  input  logic [XLEN-1:0]      rf_rd1_data,
  input  logic [XLEN-1:0]      rf_rd2_data,
  input  logic [NBYP-1:0]      byp_valid,
  input  logic [RAW*NBYP-1:0]  byp_addr,
  input  logic [XLEN*NBYP-1:0] byp_data,
  input  logic                 ld_done_valid,
  input  logic [RAW-1:0]       ld_done_rd,
  input  logic [XLEN-1:0]      ld_done_data,
  input  logic                 flush_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_pc,
  output logic [XLEN-1:0]      out_imm,
  output logic [OPW-1:0]       out_op,
  output logic [RAW-1:0]       out_rd,
  output logic                 out_is_load,
  output logic [XLEN-1:0]      out_rs1,
  output logic [XLEN-1:0]      out_rs2,
  output logic                 ld_err_out
);

  localparam int CNTW = $clog2(LD_DEPTH + 1);

  logic [CNTW-1:0] r_cnt [NREG];
  logic [CNTW-1:0] r_ld_cnt;
  logic            r_ld_err;
  logic            r_out_valid;
  logic [XLEN-1:0] r_out_pc;
  logic [XLEN-1:0] r_out_imm;
  logic [OPW-1:0]  r_out_op;
  logic [RAW-1:0]  r_out_rd;
  logic            r_out_is_load;
  logic [XLEN-1:0] r_out_rs1;
  logic [XLEN-1:0] r_out_rs2;

  logic [XLEN-1:0] w_rs1_data;
  logic [XLEN-1:0] w_rs2_data;
  logic            w_haz1;
  logic            w_haz2;
  logic            w_ld_any;
  logic            w_ld_retire;
  logic            w_struct;
  logic            w_ready;
  logic            w_accept;
  logic            w_inc;
  logic            w_same;
  logic            w_dec_ok;

  assign rf_rd1_addr = in_rs1_addr;
  assign rf_rd2_addr = in_rs2_addr;

  id_operand_select #(.NBYP(NBYP), .XLEN(XLEN), .CNTW(CNTW)) u_sel_rs1 (
    .i_en(in_rs1_en), .i_addr(in_rs1_addr), .i_rf_data(rf_rd1_data),
    .i_byp_valid(byp_valid), .i_byp_addr(byp_addr), .i_byp_data(byp_data),
    .i_ld_valid(ld_done_valid), .i_ld_rd(ld_done_rd), .i_ld_data(ld_done_data),
    .i_cnt(r_cnt[in_rs1_addr]), .o_data(w_rs1_data), .o_hazard(w_haz1)
  );

  id_operand_select #(.NBYP(NBYP), .XLEN(XLEN), .CNTW(CNTW)) u_sel_rs2 (
    .i_en(in_rs2_en), .i_addr(in_rs2_addr), .i_rf_data(rf_rd2_data),
    .i_byp_valid(byp_valid), .i_byp_addr(byp_addr), .i_byp_data(byp_data),
    .i_ld_valid(ld_done_valid), .i_ld_rd(ld_done_rd), .i_ld_data(ld_done_data),
    .i_cnt(r_cnt[in_rs2_addr]), .o_data(w_rs2_data), .o_hazard(w_haz2)
  );

  // Only a writeback that actually retires a tracked load frees a slot.
  assign w_ld_any    = ld_done_valid && (ld_done_rd != {RAW{1'b0}});
  assign w_ld_retire = w_ld_any && (r_cnt[ld_done_rd] != {CNTW{1'b0}});
  assign w_struct    = in_is_load && (r_ld_cnt == CNTW'(LD_DEPTH)) && !w_ld_retire;
  assign w_ready     = !w_haz1 && !w_haz2 && !w_struct && !flush_in &&
                       (!r_out_valid || out_ready);
  assign in_ready    = w_ready;
  assign w_accept    = in_valid && w_ready;

  assign w_inc    = w_accept && in_is_load && (in_rd_addr != {RAW{1'b0}});
  assign w_same   = w_inc && w_ld_any && (in_rd_addr == ld_done_rd);
  assign w_dec_ok = w_ld_retire || w_same;

  // Scoreboard: per-register and total outstanding-load counters.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int r = 0; r < NREG; r++) begin
        r_cnt[r] <= {CNTW{1'b0}};
      end
      r_ld_cnt <= {CNTW{1'b0}};
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (w_inc && !w_same && (in_rd_addr == RAW'(r)) && (r_cnt[r] != CNTW'(LD_DEPTH))) begin
          r_cnt[r] <= r_cnt[r] + CNTW'(1);
        end else if (w_dec_ok && !w_same && (ld_done_rd == RAW'(r))) begin
          r_cnt[r] <= r_cnt[r] - CNTW'(1);
        end else begin
          r_cnt[r] <= r_cnt[r];
        end
      end
      if (w_inc && !w_dec_ok) begin
        r_ld_cnt <= r_ld_cnt + CNTW'(1);
      end else if (!w_inc && w_dec_ok) begin
        r_ld_cnt <= r_ld_cnt - CNTW'(1);
      end else begin
        r_ld_cnt <= r_ld_cnt;
      end
    end
  end

  // Sticky flag for a writeback with nothing outstanding on that register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_ld_err <= 1'b0;
    end else if (w_ld_any && !w_dec_ok) begin
      r_ld_err <= 1'b1;
    end else begin
      r_ld_err <= r_ld_err;
    end
  end

  // Output pipeline register; payload only changes on acceptance.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_out_valid   <= 1'b0;
      r_out_pc      <= {XLEN{1'b0}};
      r_out_imm     <= {XLEN{1'b0}};
      r_out_op      <= {OPW{1'b0}};
      r_out_rd      <= {RAW{1'b0}};
      r_out_is_load <= 1'b0;
      r_out_rs1     <= {XLEN{1'b0}};
      r_out_rs2     <= {XLEN{1'b0}};
    end else if (flush_in) begin
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_out_valid   <= 1'b1;
      r_out_pc      <= in_pc;
      r_out_imm     <= in_imm;
      r_out_op      <= in_op;
      r_out_rd      <= in_rd_addr;
      r_out_is_load <= in_is_load;
      r_out_rs1     <= w_rs1_data;
      r_out_rs2     <= w_rs2_data;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= r_out_valid;
    end
  end

  assign out_valid   = r_out_valid;
  assign out_pc      = r_out_pc;
  assign out_imm     = r_out_imm;
  assign out_op      = r_out_op;
  assign out_rd      = r_out_rd;
  assign out_is_load = r_out_is_load;
  assign out_rs1     = r_out_rs1;
  assign out_rs2     = r_out_rs2;
  assign ld_err_out  = r_ld_err;

endmodule

// File: tb/tb_id_operand_stage.sv
// Self-checking bench for id_operand_stage: directed scenarios followed by
// random traffic, all checked against a behavioural reference model.
module tb_id_operand_stage;
  import id_operand_stage_pkg::*;

  localparam int XLEN = 32;
  localparam int NBYP = 2;
  localparam int LD_DEPTH = 4;
  localparam int OPW = 6;

  logic                 clk_in = 1'b0;
  logic                 rst_n_in;
  logic                 in_valid, in_ready;
  logic [XLEN-1:0]      in_pc, in_imm;
  logic [OPW-1:0]       in_op;
  logic                 in_rs1_en, in_rs2_en;
  logic [4:0]           in_rs1_addr, in_rs2_addr, in_rd_addr;
  logic                 in_is_load;
  logic [4:0]           rf_rd1_addr, rf_rd2_addr;
  logic [XLEN-1:0]      rf_rd1_data, rf_rd2_data;
  logic [NBYP-1:0]      byp_valid;
  logic [5*NBYP-1:0]    byp_addr;
  logic [XLEN*NBYP-1:0] byp_data;
  logic                 ld_done_valid;
  logic [4:0]           ld_done_rd;
  logic [XLEN-1:0]      ld_done_data;
  logic                 flush_in;
  logic                 out_valid, out_ready;
  logic [XLEN-1:0]      out_pc, out_imm;
  logic [OPW-1:0]       out_op;
  logic [4:0]           out_rd;
  logic                 out_is_load;
  logic [XLEN-1:0]      out_rs1, out_rs2;
  logic                 ld_err_out;

  id_operand_stage #(.XLEN(XLEN), .NBYP(NBYP), .LD_DEPTH(LD_DEPTH), .OPW(OPW)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_imm(in_imm), .in_op(in_op), .in_rs1_en(in_rs1_en),
    .in_rs2_en(in_rs2_en), .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
    .in_rd_addr(in_rd_addr), .in_is_load(in_is_load), .rf_rd1_addr(rf_rd1_addr),
    .rf_rd2_addr(rf_rd2_addr), .rf_rd1_data(rf_rd1_data), .rf_rd2_data(rf_rd2_data),
    .byp_valid(byp_valid), .byp_addr(byp_addr), .byp_data(byp_data),
    .ld_done_valid(ld_done_valid), .ld_done_rd(ld_done_rd), .ld_done_data(ld_done_data),
    .flush_in(flush_in), .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_imm(out_imm), .out_op(out_op), .out_rd(out_rd), .out_is_load(out_is_load),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .ld_err_out(ld_err_out)
  );

  always #5 clk_in = ~clk_in;

  int total = 0;
  int bad = 0;
  logic obs_ready;
  logic [XLEN-1:0] saved_pc;

  // Reference model state
  int m_cnt [32];
  int m_ldcnt;
  bit m_err;
  bit m_ov;
  logic [XLEN-1:0] m_pc, m_imm, m_rs1, m_rs2;
  logic [OPW-1:0] m_op;
  logic [4:0] m_rd;
  bit m_isld;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int r = 0; r < 32; r++) m_cnt[r] = 0;
    m_ldcnt = 0; m_err = 0; m_ov = 0;
    m_pc = '0; m_imm = '0; m_rs1 = '0; m_rs2 = '0; m_op = '0; m_rd = '0; m_isld = 0;
  endfunction

  function automatic logic [XLEN-1:0] m_resolve(input logic en, input logic [4:0] a,
                                                input logic [XLEN-1:0] rf);
    if (!en || a == 5'd0) return '0;
    for (int k = 0; k < NBYP; k++)
      if (byp_valid[k] && byp_addr[5*k +: 5] == a) return byp_data[XLEN*k +: XLEN];
    if (ld_done_valid && ld_done_rd == a) return ld_done_data;
    return rf;
  endfunction

  function automatic bit m_hazard(input logic en, input logic [4:0] a);
    if (!en || a == 5'd0) return 0;
    if (m_cnt[a] > 1) return 1;
    return (m_cnt[a] == 1) && !(ld_done_valid && ld_done_rd == a);
  endfunction

  function automatic bit m_ready();
    bit full_stall;
    full_stall = in_is_load && (m_ldcnt == LD_DEPTH) &&
                 !(ld_done_valid && ld_done_rd != 5'd0 && m_cnt[ld_done_rd] > 0);
    return !m_hazard(in_rs1_en, in_rs1_addr) && !m_hazard(in_rs2_en, in_rs2_addr) &&
           !full_stall && !flush_in && (!m_ov || out_ready);
  endfunction

  // One clock: check combinational outputs, step the model, check registered outputs.
  task automatic cycle();
    bit er, acc, inc, ld_any, same, dec_ok;
    logic [XLEN-1:0] e1, e2;
    #1;
    er = m_ready();
    e1 = m_resolve(in_rs1_en, in_rs1_addr, rf_rd1_data);
    e2 = m_resolve(in_rs2_en, in_rs2_addr, rf_rd2_data);
    obs_ready = in_ready;
    chk("in_ready", 64'(in_ready), 64'(er));
    chk("rf_rd1_addr", 64'(rf_rd1_addr), 64'(in_rs1_addr));
    chk("rf_rd2_addr", 64'(rf_rd2_addr), 64'(in_rs2_addr));
    acc = in_valid && er;
    inc = acc && in_is_load && in_rd_addr != 5'd0;
    ld_any = ld_done_valid && ld_done_rd != 5'd0;
    same = inc && ld_any && in_rd_addr == ld_done_rd;
    dec_ok = ld_any && (m_cnt[ld_done_rd] > 0 || same);
    @(posedge clk_in);
    if (ld_any && !dec_ok) m_err = 1;
    if (!same) begin
      if (inc && m_cnt[in_rd_addr] < LD_DEPTH) m_cnt[in_rd_addr]++;
      if (dec_ok) m_cnt[ld_done_rd]--;
    end
    m_ldcnt = m_ldcnt + int'(inc) - int'(dec_ok);
    if (flush_in) m_ov = 0;
    else if (acc) begin
      m_ov = 1; m_pc = in_pc; m_imm = in_imm; m_op = in_op; m_rd = in_rd_addr;
      m_isld = in_is_load; m_rs1 = e1; m_rs2 = e2;
    end else if (out_ready) m_ov = 0;
    #1;
    chk("out_valid", 64'(out_valid), 64'(m_ov));
    chk("out_pc", 64'(out_pc), 64'(m_pc));
    chk("out_imm", 64'(out_imm), 64'(m_imm));
    chk("out_op", 64'(out_op), 64'(m_op));
    chk("out_rd", 64'(out_rd), 64'(m_rd));
    chk("out_is_load", 64'(out_is_load), 64'(m_isld));
    chk("out_rs1", 64'(out_rs1), 64'(m_rs1));
    chk("out_rs2", 64'(out_rs2), 64'(m_rs2));
    chk("ld_err_out", 64'(ld_err_out), 64'(m_err));
    @(negedge clk_in);
  endtask

  task automatic idle();
    in_valid = 0; in_pc = '0; in_imm = '0; in_op = '0;
    in_rs1_en = 0; in_rs2_en = 0; in_rs1_addr = '0; in_rs2_addr = '0; in_rd_addr = '0;
    in_is_load = 0; rf_rd1_data = '0; rf_rd2_data = '0;
    byp_valid = '0; byp_addr = '0; byp_data = '0;
    ld_done_valid = 0; ld_done_rd = '0; ld_done_data = '0;
    flush_in = 0; out_ready = 1;
  endtask

  task automatic set_op(input logic [OPW-1:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic ld);
    in_valid = 1; in_op = op; in_pc = $urandom; in_imm = $urandom;
    in_rs1_en = 1; in_rs2_en = !ld; in_rs1_addr = rs1; in_rs2_addr = rs2;
    in_rd_addr = rd; in_is_load = ld;
  endtask

  task automatic done(input logic [4:0] rd, input logic [XLEN-1:0] d);
    ld_done_valid = 1; ld_done_rd = rd; ld_done_data = d;
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic do_reset();
    rst_n_in = 0;
    model_reset();
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_pc", 64'(out_pc), 64'd0);
    chk("rst_out_rs1", 64'(out_rs1), 64'd0);
    chk("rst_out_rd", 64'(out_rd), 64'd0);
    chk("rst_ld_err", 64'(ld_err_out), 64'd0);
    @(negedge clk_in);
    rst_n_in = 1;
  endtask

  initial begin
    logic [4:0] pick [$];
    idle();
    rst_n_in = 1;
    @(negedge clk_in);
    do_reset();

    // ADD x3,x1,x2 from the register file
    set_op(INST_ADD, 5'd1, 5'd2, 5'd3, 1'b0);
    rf_rd1_data = 32'd5; rf_rd2_data = 32'd7;
    cycle();
    chk("add_ready", 64'(obs_ready), 64'd1);
    chk("add_valid", 64'(out_valid), 64'd1);
    chk("add_rs1", 64'(out_rs1), 64'd5);
    chk("add_rs2", 64'(out_rs2), 64'd7);
    chk("add_rd", 64'(out_rd), 64'd3);

    // Bypass priority, then x0 ignores a matching bypass
    set_op(INST_ADD, 5'd1, 5'd2, 5'd3, 1'b0);
    byp_valid = 2'b11; byp_addr = {5'd1, 5'd1}; byp_data = {32'h11, 32'h22};
    cycle();
    chk("byp_prio", 64'(out_rs1), 64'h22);
    set_op(INST_ADD, 5'd0, 5'd2, 5'd3, 1'b0);
    byp_valid = 2'b01; byp_addr = {5'd1, 5'd0}; byp_data = {32'h11, 32'h33};
    cycle();
    chk("x0_zero", 64'(out_rs1), 64'd0);
    chk("x0_rs2_rf", 64'(out_rs2), 64'd7);
    byp_valid = '0;

    // Load-use stall resolved by the load's own writeback
    set_op(INST_LW, 5'd1, 5'd0, 5'd4, 1'b1);
    cycle();
    set_op(INST_ADD, 5'd4, 5'd4, 5'd5, 1'b0);
    rf_rd1_data = 32'd9; rf_rd2_data = 32'd9;
    cycle();
    chk("lu_stall0", 64'(obs_ready), 64'd0);
    cycle();
    chk("lu_stall1", 64'(obs_ready), 64'd0);
    done(5'd4, 32'hAB);
    cycle();
    chk("lu_release", 64'(obs_ready), 64'd1);
    chk("lu_rs1", 64'(out_rs1), 64'hAB);
    chk("lu_rs2", 64'(out_rs2), 64'hAB);
    ld_done_valid = 0;
    set_op(INST_ADD, 5'd4, 5'd4, 5'd5, 1'b0);
    cycle();
    chk("lu_cnt_zero", 64'(obs_ready), 64'd1);
    chk("lu_rf", 64'(out_rs1), 64'd9);

    // Fill the load tracker, then a simultaneous retire lets a 5th in
    for (int r = 6; r <= 9; r++) begin
      set_op(INST_LW, 5'd1, 5'd0, 5'(r), 1'b1);
      cycle();
      chk("fill_ready", 64'(obs_ready), 64'd1);
    end
    set_op(INST_LW, 5'd1, 5'd0, 5'd10, 1'b1);
    cycle();
    chk("full_stall", 64'(obs_ready), 64'd0);
    done(5'd6, 32'h66);
    cycle();
    chk("full_swap", 64'(obs_ready), 64'd1);
    ld_done_valid = 0;
    set_op(INST_LW, 5'd1, 5'd0, 5'd11, 1'b1);
    cycle();
    chk("still_full", 64'(obs_ready), 64'd0);
    in_valid = 0; in_is_load = 0;
    for (int r = 7; r <= 10; r++) begin
      done(5'(r), 32'(r));
      cycle();
    end
    ld_done_valid = 0;

    // Backpressure hold, then flush keeps the scoreboard
    set_op(INST_LW, 5'd1, 5'd0, 5'd12, 1'b1);
    saved_pc = in_pc;
    cycle();
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      set_op(INST_ADD, 5'd1, 5'd2, 5'd13, 1'b0);
      cycle();
      chk("hold_ready", 64'(obs_ready), 64'd0);
      chk("hold_pc", 64'(out_pc), 64'(saved_pc));
      chk("hold_valid", 64'(out_valid), 64'd1);
    end
    flush_in = 1;
    cycle();
    chk("flush_ready", 64'(obs_ready), 64'd0);
    chk("flush_valid", 64'(out_valid), 64'd0);
    flush_in = 0; out_ready = 1;
    set_op(INST_ADD, 5'd12, 5'd2, 5'd13, 1'b0);
    cycle();
    chk("flush_keeps_cnt", 64'(obs_ready), 64'd0);
    done(5'd12, 32'hC0DE);
    cycle();
    chk("flush_retire", 64'(obs_ready), 64'd1);
    chk("flush_fwd", 64'(out_rs1), 64'hC0DE);
    idle();

    // Underflow error is sticky until reset
    done(5'd10, 32'h1);
    cycle();
    chk("err_set", 64'(ld_err_out), 64'd1);
    ld_done_valid = 0;
    cycle();
    chk("err_sticky", 64'(ld_err_out), 64'd1);
    do_reset();
    cycle();
    chk("post_rst_ready", 64'(obs_ready), 64'd1);

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_pc = $urandom; in_imm = $urandom; in_op = OPW'($urandom_range(0, 63));
      in_rs1_en = 1'($urandom); in_rs2_en = 1'($urandom);
      in_rs1_addr = 5'($urandom_range(0, 7)); in_rs2_addr = 5'($urandom_range(0, 7));
      in_rd_addr = 5'($urandom_range(0, 7));
      in_is_load = ($urandom_range(0, 2) == 0);
      rf_rd1_data = $urandom; rf_rd2_data = $urandom;
      byp_valid = 2'($urandom);
      byp_addr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      byp_data = {32'($urandom), 32'($urandom)};
      ld_done_valid = ($urandom_range(0, 2) == 0);
      pick.delete();
      for (int r = 1; r < 8; r++) if (m_cnt[r] > 0) pick.push_back(5'(r));
      if (pick.size() > 0 && $urandom_range(0, 7) != 0)
        ld_done_rd = pick[$urandom_range(0, pick.size() - 1)];
      else
        ld_done_rd = 5'($urandom_range(1, 7));
      ld_done_data = $urandom;
      flush_in = ($urandom_range(0, 19) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
